knn_vote: RTL and testbench

- Downstream consumer of the distance stage in the KNN system.
- Receives one (distance, training type) pair per training sample and keeps the K smallest distances in a sorted list.
- After L samples, runs a majority vote and returns inferred_type with a one-cycle inference_done to the memory controller, which writes the result back.

---
 rtl/knn_pkg.sv | 45 ++++
 rtl/knn_sorted_list.sv | 97 +++++++++
 rtl/knn_vote.sv | 194 +++++++++++++++++++
 tb/tb_knn_vote.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types and width helpers for the KNN vote stage.
// FSM encoding, empty-distance constant and counter width calculations.
package knn_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VOTE    = 2'd1,
    ARGMAX  = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [63:0] DIST_MAX = {64{1'b1}};

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    for (p = 64'd1; p < longint'(v); p = p * 64'd2) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Weighted voting lets one type collect K + (K-1) + ... + 1 at most.
  function automatic int unsigned vote_cnt_w(input int unsigned k, input bit weighted);
    int unsigned w;
    if (weighted) begin
      w = clog2(k * (k + 1) / 2 + 1);
    end else begin
      w = clog2(k + 1);
    end
    return w;
  endfunction

  function automatic int unsigned rank_w(input int unsigned k);
    int unsigned w;
    if (k > 1) begin
      w = clog2(k);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/knn_sorted_list.sv
// K-entry ascending distance list with single-cycle parallel compare-shift insert.
// Invalid slots hold all-ones and always compare as greater than any new distance.
module knn_sorted_list
  import knn_pkg::*;
#(
  parameter int unsigned K      = 5,
  parameter int unsigned DIST_W = 32,
  parameter int unsigned TYPE_W = 4,
  parameter int unsigned RANK_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ins_en,
  input  logic [DIST_W-1:0] ins_dist,
  input  logic [TYPE_W-1:0] ins_type,
  input  logic [RANK_W-1:0] rd_rank,
  output logic [DIST_W-1:0] rd_dist,
  output logic [TYPE_W-1:0] rd_type,
  output logic              rd_valid
);

  localparam logic [DIST_W-1:0] EMPTY_DIST = DIST_MAX[DIST_W-1:0];

  logic [DIST_W-1:0] dist_r     [K];
  logic [TYPE_W-1:0] type_r     [K];
  logic [K-1:0]      valid_r;
  logic [DIST_W-1:0] nxt_dist_s [K];
  logic [TYPE_W-1:0] nxt_type_s [K];
  logic [K-1:0]      nxt_valid_s;
  logic [K-1:0]      gt_s;

  // Rank i takes the new entry at the first strictly-greater slot, or its upper neighbour below it.
  always_comb begin
    gt_s = '0;
    for (int i = 0; i < K; i++) begin
      gt_s[i] = !valid_r[i] || (dist_r[i] > ins_dist);
    end
    if (gt_s[0]) begin
      nxt_dist_s[0]  = ins_dist;
      nxt_type_s[0]  = ins_type;
      nxt_valid_s[0] = 1'b1;
    end else begin
      nxt_dist_s[0]  = dist_r[0];
      nxt_type_s[0]  = type_r[0];
      nxt_valid_s[0] = valid_r[0];
    end
    for (int i = 1; i < K; i++) begin
      if (gt_s[i] && !gt_s[i-1]) begin
        nxt_dist_s[i]  = ins_dist;
        nxt_type_s[i]  = ins_type;
        nxt_valid_s[i] = 1'b1;
      end else if (gt_s[i]) begin
        nxt_dist_s[i]  = dist_r[i-1];
        nxt_type_s[i]  = type_r[i-1];
        nxt_valid_s[i] = valid_r[i-1];
      end else begin
        nxt_dist_s[i]  = dist_r[i];
        nxt_type_s[i]  = type_r[i];
        nxt_valid_s[i] = valid_r[i];
      end
    end
  end

  // List storage: emptied on reset or clear, otherwise updated on insert.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < K; i++) begin
        dist_r[i] <= EMPTY_DIST;
        type_r[i] <= '0;
      end
      valid_r <= '0;
    end else if (ins_en) begin
      for (int i = 0; i < K; i++) begin
        dist_r[i] <= nxt_dist_s[i];
        type_r[i] <= nxt_type_s[i];
      end
      valid_r <= nxt_valid_s;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Read port used by the voting sweep.
  always_comb begin
    if (int'(rd_rank) < K) begin
      rd_dist  = dist_r[rd_rank];
      rd_type  = type_r[rd_rank];
      rd_valid = valid_r[rd_rank];
    end else begin
      rd_dist  = EMPTY_DIST;
      rd_type  = '0;
      rd_valid = 1'b0;
    end
  end

endmodule

// File: rtl/knn_vote.sv
// KNN vote stage: keeps the K nearest of L samples, then majority-votes their types.
// Define KNN_WEIGHTED_VOTE_EN to weight rank r by K-r instead of 1.
module knn_vote
  import knn_pkg::*;
#(
  parameter int unsigned K         = 5,
  parameter int unsigned L         = 64,
  parameter int unsigned TYPE_W    = 4,
  parameter int unsigned NUM_TYPES = 16,
  parameter int unsigned DIST_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dist_valid,
  output logic              dist_ready,
  input  logic [DIST_W-1:0] dist_in,
  input  logic [TYPE_W-1:0] type_in,
  output logic [TYPE_W-1:0] inferred_type,
  output logic              inference_done,
  output logic              busy
);

`ifdef KNN_WEIGHTED_VOTE_EN
  localparam bit WEIGHTED = 1'b1;
`else
  localparam bit WEIGHTED = 1'b0;
`endif

  localparam int unsigned CNT_W  = vote_cnt_w(K, WEIGHTED);
  localparam int unsigned RANK_W = rank_w(K);
  localparam int unsigned SAMP_W = (L > 1) ? clog2(L) : 1;

  state_e            state_r, state_next_s;
  logic [SAMP_W-1:0] samp_cnt_r;
  logic [RANK_W-1:0] rank_r;
  logic [TYPE_W-1:0] scan_r;
  logic [CNT_W-1:0]  counts_r [NUM_TYPES];
  logic [TYPE_W-1:0] best_type_r, best_type_next_s;
  logic [CNT_W-1:0]  best_cnt_r, best_cnt_next_s;
  logic [CNT_W-1:0]  scan_cnt_s;
  logic [CNT_W-1:0]  weight_s;
  logic [TYPE_W-1:0] inferred_type_r;
  logic              inference_done_r;
  logic              dist_ready_r;
  logic              busy_r;
  logic              accept_s;
  logic              last_sample_s;
  logic              vote_en_s;
  logic [DIST_W-1:0] rd_dist_s;
  logic [TYPE_W-1:0] rd_type_s;
  logic              rd_valid_s;
  logic              unused_dist_s;

  assign dist_ready     = dist_ready_r;
  assign busy           = busy_r;
  assign inferred_type  = inferred_type_r;
  assign inference_done = inference_done_r;
  assign unused_dist_s  = ^rd_dist_s;

  knn_sorted_list #(
    .K      (K),
    .DIST_W (DIST_W),
    .TYPE_W (TYPE_W),
    .RANK_W (RANK_W)
  ) u_list (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_r == DONE),
    .ins_en   (accept_s),
    .ins_dist (dist_in),
    .ins_type (type_in),
    .rd_rank  (rank_r),
    .rd_dist  (rd_dist_s),
    .rd_type  (rd_type_s),
    .rd_valid (rd_valid_s)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_next_s  = state_r;
    accept_s      = dist_valid && dist_ready_r;
    last_sample_s = (samp_cnt_r == SAMP_W'(L - 1));
    case (state_r)
      COLLECT: begin
        if (accept_s && last_sample_s) begin
          state_next_s = VOTE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      VOTE: begin
        if (rank_r == RANK_W'(K - 1)) begin
          state_next_s = ARGMAX;
        end else begin
          state_next_s = VOTE;
        end
      end
      ARGMAX: begin
        if (scan_r == TYPE_W'(NUM_TYPES - 1)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ARGMAX;
        end
      end
      DONE:    state_next_s = COLLECT;
      default: state_next_s = COLLECT;
    endcase
  end

  // Vote weight for the current rank and running argmax; strict compare keeps the lowest type on ties.
  always_comb begin
    if (WEIGHTED) begin
      weight_s = CNT_W'(K) - CNT_W'(rank_r);
    end else begin
      weight_s = {{(CNT_W-1){1'b0}}, 1'b1};
    end
    vote_en_s  = (state_r == VOTE) && rd_valid_s;
    scan_cnt_s = counts_r[scan_r];
    if (scan_cnt_s > best_cnt_r) begin
      best_type_next_s = scan_r;
      best_cnt_next_s  = scan_cnt_s;
    end else begin
      best_type_next_s = best_type_r;
      best_cnt_next_s  = best_cnt_r;
    end
  end

  // Sequencing state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= COLLECT;
      samp_cnt_r       <= '0;
      rank_r           <= '0;
      scan_r           <= '0;
      best_type_r      <= '0;
      best_cnt_r       <= '0;
      inferred_type_r  <= '0;
      inference_done_r <= 1'b0;
      dist_ready_r     <= 1'b1;
      busy_r           <= 1'b0;
      for (int i = 0; i < NUM_TYPES; i++) begin
        counts_r[i] <= '0;
      end
    end else begin
      state_r          <= state_next_s;
      dist_ready_r     <= (state_next_s == COLLECT);
      busy_r           <= (state_next_s != COLLECT);
      inference_done_r <= (state_next_s == DONE);

      if (accept_s) begin
        if (last_sample_s) begin
          samp_cnt_r <= '0;
        end else begin
          samp_cnt_r <= samp_cnt_r + {{(SAMP_W-1){1'b0}}, 1'b1};
        end
      end else begin
        samp_cnt_r <= samp_cnt_r;
      end

      if (state_r == VOTE && state_next_s == VOTE) begin
        rank_r <= rank_r + {{(RANK_W-1){1'b0}}, 1'b1};
      end else begin
        rank_r <= '0;
      end

      if (state_r == ARGMAX) begin
        scan_r      <= scan_r + {{(TYPE_W-1){1'b0}}, 1'b1};
        best_type_r <= best_type_next_s;
        best_cnt_r  <= best_cnt_next_s;
      end else begin
        scan_r      <= '0;
        best_type_r <= '0;
        best_cnt_r  <= '0;
      end

      if (state_r == ARGMAX && state_next_s == DONE) begin
        inferred_type_r <= best_type_next_s;
      end else begin
        inferred_type_r <= inferred_type_r;
      end

      for (int i = 0; i < NUM_TYPES; i++) begin
        if (state_r == DONE) begin
          counts_r[i] <= '0;
        end else if (vote_en_s && rd_type_s == TYPE_W'(i)) begin
          counts_r[i] <= counts_r[i] + weight_s;
        end else begin
          counts_r[i] <= counts_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: a reference model pushes expected results, monitors pop on inference_done.
// Two instances: L=5 for the main runs and L=2 for the fewer-than-K-samples case.
module tb_knn_vote;

  localparam int K   = 3;
  localparam int L   = 5;
  localparam int L2  = 2;
  localparam int TW  = 2;
  localparam int NT  = 4;
  localparam int DW  = 8;
  localparam int LAT = K + NT + 1;

`ifdef KNN_WEIGHTED_VOTE_EN
  localparam bit WEIGHTED = 1'b1;
`else
  localparam bit WEIGHTED = 1'b0;
`endif

  typedef struct {
    int typ;
    int when;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dv1 = 1'b0, dv2 = 1'b0;
  logic          dr1, dr2;
  logic [DW-1:0] di1 = '0, di2 = '0;
  logic [TW-1:0] ti1 = '0, ti2 = '0;
  logic [TW-1:0] it1, it2;
  logic          done1, done2, busy1, busy2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_wait = 0;
  exp_t q1[$];
  exp_t q2[$];
  int   sd1[$], st1[$], sd2[$], st2[$];

  knn_vote #(.K(K), .L(L), .TYPE_W(TW), .NUM_TYPES(NT), .DIST_W(DW)) dut1 (
    .clk(clk), .rst(rst), .dist_valid(dv1), .dist_ready(dr1), .dist_in(di1), .type_in(ti1),
    .inferred_type(it1), .inference_done(done1), .busy(busy1)
  );

  knn_vote #(.K(K), .L(L2), .TYPE_W(TW), .NUM_TYPES(NT), .DIST_W(DW)) dut2 (
    .clk(clk), .rst(rst), .dist_valid(dv2), .dist_ready(dr2), .dist_in(di2), .type_in(ti2),
    .inferred_type(it2), .inference_done(done2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference: stable pick of the K smallest distances, tally, lowest type wins ties.
  function automatic int ref_vote(input int d[$], input int t[$]);
    bit taken[64];
    int votes[NT];
    int pick, best;
    foreach (taken[i]) taken[i] = 1'b0;
    foreach (votes[i]) votes[i] = 0;
    for (int r = 0; r < K && r < d.size(); r++) begin
      pick = -1;
      for (int i = 0; i < d.size(); i++)
        if (!taken[i] && (pick < 0 || d[i] < d[pick])) pick = i;
      taken[pick] = 1'b1;
      votes[t[pick]] += WEIGHTED ? (K - r) : 1;
    end
    best = 0;
    for (int i = 1; i < NT; i++)
      if (votes[i] > votes[best]) best = i;
    return best;
  endfunction

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done1: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("result1", int'(it1), e.typ);
        chk("latency1", cyc, e.when);
      end
    end
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done2: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("result2", int'(it2), e.typ);
        chk("latency2", cyc, e.when);
      end
    end
  end

  task automatic send1(input int d, input int t);
    int w, t0;
    dv1 = 1'b1; di1 = DW'(d); ti1 = TW'(t);
    w = 0;
    while (!dr1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    if (!dr1) begin
      checks++; errors++;
      $display("FAIL ready_timeout1: got ready=0 after %0d cycles expected 1", w);
    end else begin
      t0 = cyc;
      @(posedge clk);
      sd1.push_back(d); st1.push_back(t);
      if (sd1.size() == L) begin
        q1.push_back('{ref_vote(sd1, st1), t0 + LAT});
        sd1.delete(); st1.delete();
      end
      @(negedge clk);
    end
  endtask

  task automatic send2(input int d, input int t);
    int w, t0;
    dv2 = 1'b1; di2 = DW'(d); ti2 = TW'(t);
    w = 0;
    while (!dr2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!dr2) begin
      checks++; errors++;
      $display("FAIL ready_timeout2: got ready=0 after %0d cycles expected 1", w);
    end else begin
      t0 = cyc;
      @(posedge clk);
      sd2.push_back(d); st2.push_back(t);
      if (sd2.size() == L2) begin
        q2.push_back('{ref_vote(sd2, st2), t0 + LAT});
        sd2.delete(); st2.delete();
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    dv1 = 1'b0; dv2 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1; dv1 = 1'b0; dv2 = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int which);
    int w;
    w = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk((which == 1) ? "drain1" : "drain2", (which == 1) ? q1.size() : q2.size(), 0);
  endtask

  int rd, rt, gap;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready1", int'(dr1), 1);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_type1", int'(it1), 0);
    chk("rst_ready2", int'(dr2), 1);
    chk("rst_busy2", int'(busy2), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic ordering.
    send1(40, 1); send1(10, 2); send1(30, 1); send1(20, 1); send1(50, 3);
    chk("busy_in_vote", int'(busy1), 1);
    chk("ready_in_vote", int'(dr1), 0);
    idle(LAT + 2);
    chk("idle_after_done", int'(busy1), 0);

    // Equal distances, then hold valid straight through the vote.
    send1(10, 2); send1(10, 3); send1(10, 1); send1(99, 0); send1(99, 0);
    send1(60, 0);
    chk("ready_low_cycles", last_wait, LAT);
    send1(61, 2); send1(62, 2); send1(5, 3); send1(63, 1);
    idle(LAT + 2);

    // All-ones distances still fill invalid slots.
    send1(255, 2); send1(255, 2); send1(255, 1); send1(255, 3); send1(255, 3);
    idle(LAT + 2);

    // Reset after the 3rd accept, then a fresh inference.
    send1(1, 3); send1(2, 3); send1(3, 3);
    pulse_reset(2);
    sd1.delete(); st1.delete();
    chk("rst_mid_type", int'(it1), 0);
    chk("rst_mid_ready", int'(dr1), 1);
    send1(10, 2); send1(20, 1); send1(30, 1); send1(90, 0); send1(90, 0);
    idle(LAT + 2);

    // Reset during the vote aborts the pending result.
    send1(4, 1); send1(8, 1); send1(6, 2); send1(7, 1); send1(9, 3);
    pulse_reset(1);
    void'(q1.pop_back());
    chk("abort_busy", int'(busy1), 0);
    idle(LAT + 4);

    // Randomised inferences with occasional all-ones and random gaps.
    for (int n = 0; n < 12; n++) begin
      for (int s = 0; s < L; s++) begin
        rd  = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 24));
        rt  = int'($urandom_range(0, NT - 1));
        gap = int'($urandom_range(0, 2));
        if (gap != 0) idle(gap);
        send1(rd, rt);
      end
    end
    idle(2);
    drain(1);

    // Fewer samples than K: invalid ranks are skipped.
    send2(5, 3); send2(7, 3);
    idle(LAT + 2);
    for (int n = 0; n < 6; n++) begin
      send2(int'($urandom_range(0, 255)), int'($urandom_range(0, NT - 1)));
      send2(int'($urandom_range(0, 255)), int'($urandom_range(0, NT - 1)));
    end
    idle(2);
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
